// File: rtl/recip_pkg.sv
// Shared widths, result-word field offsets and FSM encodings for the TDC result reader.
// Field offsets describe the default {seq, fine, coarse} word layout.
package recip_pkg;

  localparam int COARSE_W_DEF   = 24;
  localparam int FINE_W_DEF     = 8;
  localparam int SEQ_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int COARSE_LSB = 0;
  localparam int FINE_LSB   = COARSE_LSB + COARSE_W_DEF;
  localparam int SEQ_LSB    = FINE_LSB + FINE_W_DEF;
  localparam int WORD_W_DEF = SEQ_LSB + SEQ_W_DEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_e;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_WAIT = 1'b1
  } out_state_e;

endpackage

// File: rtl/recip_result_fifo.sv
// Single-clock result buffer; head is combinational from storage, level updates on push/pop.
// Push when full and pop when empty are masked internally and have no effect.
module recip_result_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk_fast,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset: the head is only consumed while the level is non-zero.
  always_ff @(posedge clk_fast) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/recip_result_reader.sv
// Captures TDC results with a valid/ack handshake, buffers them and hands them to the sys domain
// over a toggle req/ack pair; capture-to-toggle is 2 cycles when idle, a full buffer holds off the ack.
module recip_result_reader
  import recip_pkg::*;
#(
  parameter int COARSE_WIDTH = COARSE_W_DEF,
  parameter int FINE_WIDTH   = FINE_W_DEF,
  parameter int SEQ_WIDTH    = SEQ_W_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  localparam int W  = SEQ_WIDTH + FINE_WIDTH + COARSE_WIDTH,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk_fast,
  input  logic                    rst,
  input  logic                    tdc_valid_fast,
  input  logic [COARSE_WIDTH-1:0] tdc_coarse_fast,
  input  logic [FINE_WIDTH-1:0]   tdc_fine_raw_fast,
  output logic                    tdc_ack_fast,
  output logic [W-1:0]            out_data,
  output logic                    out_req_tgl,
  input  logic                    out_ack_tgl,
  output logic [LW-1:0]           fifo_level
);

  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = SEQ_WIDTH'(1);

  cap_state_e           r_cap_state, w_cap_next;
  out_state_e           r_out_state, w_out_next;
  logic [SEQ_WIDTH-1:0] r_seq;
  logic                 r_ack;
  logic                 r_ack_meta, r_ack_sync;
  logic                 r_req_tgl;
  logic [W-1:0]         r_out_data;
  logic                 w_push, w_pop;
  logic                 w_full, w_empty;
  logic [W-1:0]         w_head;

  recip_result_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_fast (clk_fast),
    .rst      (rst),
    .i_push   (w_push),
    .i_data   ({r_seq, tdc_fine_raw_fast, tdc_coarse_fast}),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (fifo_level)
  );

  // WAIT_LOW blocks re-capture until the core has dropped valid after our ack.
  always_comb begin
    w_cap_next = r_cap_state;
    w_push     = 1'b0;
    case (r_cap_state)
      IDLE: begin
        if (tdc_valid_fast && !w_full) begin
          w_push     = 1'b1;
          w_cap_next = ACK;
        end
      end
      ACK:      w_cap_next = WAIT_LOW;
      WAIT_LOW: if (!tdc_valid_fast) w_cap_next = IDLE;
      default:  w_cap_next = IDLE;
    endcase
  end

  always_comb begin
    w_out_next = r_out_state;
    w_pop      = 1'b0;
    case (r_out_state)
      O_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_out_next = O_WAIT;
        end
      end
      O_WAIT:  if (r_ack_sync == r_req_tgl) w_out_next = O_IDLE;
      default: w_out_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      r_cap_state <= IDLE;
      r_out_state <= O_IDLE;
      r_seq       <= '0;
      r_ack       <= 1'b0;
      r_ack_meta  <= 1'b0;
      r_ack_sync  <= 1'b0;
      r_req_tgl   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_cap_state <= w_cap_next;
      r_out_state <= w_out_next;
      r_ack       <= (w_cap_next == ACK);
      r_ack_meta  <= out_ack_tgl;
      r_ack_sync  <= r_ack_meta;
      if (w_push) r_seq <= r_seq + SEQ_ONE;
      if (w_pop) begin
        r_out_data <= w_head;
        r_req_tgl  <= ~r_req_tgl;
      end
    end
  end

  assign tdc_ack_fast = r_ack;
  assign out_req_tgl  = r_req_tgl;
  assign out_data     = r_out_data;

endmodule

// File: tb/tb_recip_result_reader.sv
// Directed bench for recip_result_reader: acts as both the counting core and the sys-domain receiver.
module tb_recip_result_reader;

  logic        clk_fast = 1'b0;
  logic        rst;
  logic        tdc_valid_fast;
  logic [23:0] tdc_coarse_fast;
  logic [7:0]  tdc_fine_raw_fast;
  logic        tdc_ack_fast;
  logic [39:0] out_data;
  logic        out_req_tgl;
  logic        out_ack_tgl;
  logic [2:0]  fifo_level;

  always #5 clk_fast = ~clk_fast;

  recip_result_reader dut (
    .clk_fast          (clk_fast),
    .rst               (rst),
    .tdc_valid_fast    (tdc_valid_fast),
    .tdc_coarse_fast   (tdc_coarse_fast),
    .tdc_fine_raw_fast (tdc_fine_raw_fast),
    .tdc_ack_fast      (tdc_ack_fast),
    .out_data          (out_data),
    .out_req_tgl       (out_req_tgl),
    .out_ack_tgl       (out_ack_tgl),
    .fifo_level        (fifo_level)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ack_cnt  = 0;
  int          lvl_max  = 0;
  logic        last_tgl = 1'b0;
  bit          auto_ack = 1'b0;
  logic [39:0] words[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One cycle: sample at the falling edge, log presented words, optionally ack them.
  task automatic tick();
    @(negedge clk_fast);
    if (tdc_ack_fast) ack_cnt++;
    if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
    if (rst) last_tgl = 1'b0;
    else begin
      if (out_req_tgl != last_tgl) begin
        words.push_back(out_data);
        last_tgl = out_req_tgl;
      end
      if (auto_ack && out_ack_tgl != out_req_tgl) out_ack_tgl = out_req_tgl;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tdc_valid_fast = 1'b0; out_ack_tgl = 1'b0; auto_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    words.delete(); ack_cnt = 0; lvl_max = 0;
  endtask

  // Core model: hold valid until acked, then keep it low long enough for WAIT_LOW to see it.
  task automatic offer(input logic [23:0] c, input logic [7:0] f, input int budget, output bit acked);
    acked = 1'b0;
    tdc_coarse_fast = c; tdc_fine_raw_fast = f; tdc_valid_fast = 1'b1;
    for (int i = 0; i < budget && !acked; i++) begin
      tick();
      if (tdc_ack_fast) acked = 1'b1;
    end
    if (acked) begin
      tdc_valid_fast = 1'b0;
      tick(); tick();
    end
  endtask

  initial begin
    bit ok;
    int errs;
    int n;
    rst = 1'b1; tdc_valid_fast = 1'b0; out_ack_tgl = 1'b0;
    tdc_coarse_fast = '0; tdc_fine_raw_fast = '0;

    // Reset state
    tick();
    check("rst_req_tgl", out_req_tgl, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ack", tdc_ack_fast, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0; tick();
    words.delete(); ack_cnt = 0;

    // Single result and 2-cycle capture-to-toggle latency
    tdc_coarse_fast = 24'h0186A0; tdc_fine_raw_fast = 8'h2C; tdc_valid_fast = 1'b1;
    tick();
    check("single_ack_c1", tdc_ack_fast, 1);
    check("single_tgl_c1", out_req_tgl, 0);
    tdc_valid_fast = 1'b0;
    tick();
    check("single_ack_c2", tdc_ack_fast, 0);
    check("single_tgl_c2", out_req_tgl, 1);
    check("single_data", out_data, 40'h002C0186A0);
    repeat (4) tick();
    check("single_ack_cnt", ack_cnt, 1);

    // Valid held 10 cycles past the ack
    do_reset();
    auto_ack = 1'b1;
    tdc_coarse_fast = 24'h000ABC; tdc_fine_raw_fast = 8'h11; tdc_valid_fast = 1'b1;
    repeat (11) tick();
    tdc_valid_fast = 1'b0;
    repeat (8) tick();
    check("hold_pushes", ack_cnt, 1);
    check("hold_lvl_peak", lvl_max, 1);
    check("hold_words", words.size(), 1);

    // Backpressure: receiver stalls, 6 results offered
    do_reset();
    for (int k = 0; k < 5; k++) begin
      offer(24'h000100 + 24'(k), 8'(k), 10, ok);
      check("bp_offer_acked", ok, 1);
    end
    check("bp_words_presented", words.size(), 1);
    check("bp_level_full", fifo_level, 4);
    tdc_coarse_fast = 24'h000105; tdc_fine_raw_fast = 8'h05; tdc_valid_fast = 1'b1;
    repeat (20) tick();
    check("bp_sixth_not_acked", ack_cnt, 5);
    for (int k = 1; k <= 5; k++) begin
      out_ack_tgl = out_req_tgl;
      n = 0;
      while (words.size() < k + 1 && n < 20) begin
        tick();
        if (tdc_valid_fast && tdc_ack_fast) tdc_valid_fast = 1'b0;
        n++;
      end
      check("bp_word_arrived", words.size() >= k + 1, 1);
    end
    check("bp_total_acks", ack_cnt, 6);
    for (int k = 0; k < 6 && k < words.size(); k++) begin
      check("bp_word_seq", words[k][39:32], k);
      check("bp_word_coarse", words[k][23:0], 24'h000100 + 24'(k));
    end

    // Simultaneous push and pop at level 2
    do_reset();
    for (int k = 0; k < 3; k++) offer(24'h000200 + 24'(k), 8'hA0 + 8'(k), 10, ok);
    check("pp_level_pre", fifo_level, 2);
    out_ack_tgl = out_req_tgl;
    repeat (3) tick();
    tdc_coarse_fast = 24'h000203; tdc_fine_raw_fast = 8'hA3; tdc_valid_fast = 1'b1;
    tick();
    check("pp_ack", tdc_ack_fast, 1);
    check("pp_level_same", fifo_level, 2);
    check("pp_words", words.size(), 2);
    tdc_valid_fast = 1'b0;
    auto_ack = 1'b1;
    n = 0;
    while (words.size() < 4 && n < 60) begin tick(); n++; end
    check("pp_all_words", words.size(), 4);
    for (int k = 0; k < 4 && k < words.size(); k++)
      check("pp_order", words[k], {8'(k), 8'hA0 + 8'(k), 24'h000200 + 24'(k)});

    // Reset while O_WAIT with 3 buffered words
    do_reset();
    for (int k = 0; k < 4; k++) offer(24'h000300 + 24'(k), 8'h30, 10, ok);
    check("rw_level_pre", fifo_level, 3);
    check("rw_tgl_pre", out_req_tgl, 1);
    rst = 1'b1;
    tick();
    check("rw_tgl", out_req_tgl, 0);
    check("rw_level", fifo_level, 0);
    check("rw_ack", tdc_ack_fast, 0);
    rst = 1'b0; out_ack_tgl = 1'b0;
    tick();
    words.delete();
    offer(24'h000777, 8'h77, 10, ok);
    tick();
    check("rw_next_words", words.size(), 1);
    if (words.size() > 0) check("rw_next_seq", words[0], 40'h0077000777);

    // 260 back-to-back results across the seq wrap
    do_reset();
    auto_ack = 1'b1;
    errs = 0;
    for (int i = 0; i < 260; i++) begin
      offer(24'(i), 8'h5A, 40, ok);
      if (!ok) errs++;
    end
    check("wrap_all_acked", errs, 0);
    n = 0;
    while (words.size() < 260 && n < 200) begin tick(); n++; end
    check("wrap_count", words.size(), 260);
    errs = 0;
    for (int i = 0; i < words.size(); i++) begin
      if (words[i][39:32] !== 8'(i) || words[i][23:0] !== 24'(i)) errs++;
    end
    check("wrap_seq_gaps", errs, 0);
    if (words.size() >= 258) begin
      check("wrap_seq_ff", words[255][39:32], 8'hFF);
      check("wrap_seq_00", words[256][39:32], 8'h00);
      check("wrap_seq_01", words[257][39:32], 8'h01);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
